regfile_wb_arbiter: RTL and testbench

//  Shares the two register-file write ports (port A = Rd_*, port B = Rs_*) among three

---
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: up to two of three requesters (ALU, load, move/imm) win the two register-file write ports each cycle, round-robin.
// Latency: a grant accepted at edge N is driven on Rd_*/Rs_* during the cycle after edge N.
// Backpressure: Req_Ready is combinational; Hold/Reset or a port or address conflict leaves a request pending.
//
// Ports:
//   Clock, Reset (sync, active-high), Hold (grant nothing this cycle)
//   Req_Valid/Req_Addr/Req_Data/Req_Ready : three packed requester lanes, lane i at [i*W +: W]
//   Rd_Wen/Rd_WAddr/Rd_WData              : register-file write port A (first grant)
//   Rs_Wen/Rs_WAddr/Rs_WData              : register-file write port B (second grant)
//   Err_Addr                              : one-cycle pulse after an out-of-range request was consumed
module regfile_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Hold,
    input  logic [2:0]            Req_Valid,
    input  logic [3*ADDR_W-1:0]   Req_Addr,
    input  logic [3*DATA_W-1:0]   Req_Data,
    output logic [2:0]            Req_Ready,
    output logic                  Rd_Wen,
    output logic [ADDR_W-1:0]     Rd_WAddr,
    output logic [DATA_W-1:0]     Rd_WData,
    output logic                  Rs_Wen,
    output logic [ADDR_W-1:0]     Rs_WAddr,
    output logic [DATA_W-1:0]     Rs_WData,
    output logic                  Err_Addr
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_CMP = (ADDR_W+1)'(NUM_REGS);

    logic [1:0]        rr;

    logic [ADDR_W-1:0] addr_arr [0:2];
    logic [DATA_W-1:0] data_arr [0:2];
    logic [2:0]        out_of_range;

    logic              a_grant;
    logic [1:0]        a_sel;
    logic              b_grant;
    logic [1:0]        b_sel;
    logic              err_nxt;
    logic              consumed;
    logic [1:0]        last_idx;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            addr_arr[i]     = Req_Addr[i*ADDR_W +: ADDR_W];
            data_arr[i]     = Req_Data[i*DATA_W +: DATA_W];
            out_of_range[i] = ({1'b0, addr_arr[i]} >= NUM_REGS_CMP);
        end
    end

    // Scan from the round-robin pointer. Out-of-range requests are swallowed
    // without taking a port; in-range ones fill A then B, and B may not alias
    // A's address so the register file never sees two writes to one register.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        Req_Ready = '0;
        a_grant   = 1'b0;
        a_sel     = 2'd0;
        b_grant   = 1'b0;
        b_sel     = 2'd0;
        err_nxt   = 1'b0;
        consumed  = 1'b0;
        last_idx  = rr;
        sum       = '0;
        idx       = '0;
        if (!Reset && !Hold) begin
            for (int k = 0; k < 3; k++) begin
                sum = {1'b0, rr} + 3'(k);
                idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (Req_Valid[idx]) begin
                    if (out_of_range[idx]) begin
                        Req_Ready[idx] = 1'b1;
                        err_nxt        = 1'b1;
                        consumed       = 1'b1;
                        last_idx       = idx;
                    end else if (!a_grant) begin
                        Req_Ready[idx] = 1'b1;
                        a_grant        = 1'b1;
                        a_sel          = idx;
                        consumed       = 1'b1;
                        last_idx       = idx;
                    end else if (!b_grant && (addr_arr[idx] != addr_arr[a_sel])) begin
                        Req_Ready[idx] = 1'b1;
                        b_grant        = 1'b1;
                        b_sel          = idx;
                        consumed       = 1'b1;
                        last_idx       = idx;
                    end
                end
            end
        end
    end

    // Ports keep their last address/data when idle; only Wen drops.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rr       <= 2'd0;
            Rd_Wen   <= 1'b0;
            Rd_WAddr <= '0;
            Rd_WData <= '0;
            Rs_Wen   <= 1'b0;
            Rs_WAddr <= '0;
            Rs_WData <= '0;
            Err_Addr <= 1'b0;
        end else begin
            Rd_Wen   <= a_grant;
            Rs_Wen   <= b_grant;
            Err_Addr <= err_nxt;
            if (a_grant) begin
                Rd_WAddr <= addr_arr[a_sel];
                Rd_WData <= data_arr[a_sel];
            end
            if (b_grant) begin
                Rs_WAddr <= addr_arr[b_sel];
                Rs_WData <= data_arr[b_sel];
            end
            if (consumed) begin
                rr <= (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 16;

    logic                Clock;
    logic                Reset;
    logic                Hold;
    logic [2:0]          Req_Valid;
    logic [3*ADDR_W-1:0] Req_Addr;
    logic [3*DATA_W-1:0] Req_Data;
    logic [2:0]          Req_Ready;
    logic                Rd_Wen;
    logic [ADDR_W-1:0]   Rd_WAddr;
    logic [DATA_W-1:0]   Rd_WData;
    logic                Rs_Wen;
    logic [ADDR_W-1:0]   Rs_WAddr;
    logic [DATA_W-1:0]   Rs_WData;
    logic                Err_Addr;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .Clock(Clock), .Reset(Reset), .Hold(Hold),
        .Req_Valid(Req_Valid), .Req_Addr(Req_Addr), .Req_Data(Req_Data), .Req_Ready(Req_Ready),
        .Rd_Wen(Rd_Wen), .Rd_WAddr(Rd_WAddr), .Rd_WData(Rd_WData),
        .Rs_Wen(Rs_Wen), .Rs_WAddr(Rs_WAddr), .Rs_WData(Rs_WData),
        .Err_Addr(Err_Addr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic              wa;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] da;
        logic              wb;
        logic [ADDR_W-1:0] ab;
        logic [DATA_W-1:0] db;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    int                checks  = 0;
    int                errors  = 0;
    bit                started = 0;
    int                m_rr    = 0;
    logic [ADDR_W-1:0] m_aa    = '0;
    logic [DATA_W-1:0] m_da    = '0;
    logic [ADDR_W-1:0] m_ab    = '0;
    logic [DATA_W-1:0] m_db    = '0;

    // Reference rule: visit requesters starting at rr; out-of-range ones are
    // consumed for free, in-range ones take a port while fewer than two are
    // in use and their register is not already being written this cycle.
    function automatic void arbitrate(input logic [2:0] v, input int a[3], input int rr,
                                      output logic [2:0] rdy, output int ga, output int gb,
                                      output bit err, output int nrr);
        int used[$];
        int last;
        rdy = '0; ga = -1; gb = -1; err = 0; last = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            bit clash;
            i = (rr + k) % 3;
            clash = 0;
            if (v[i]) begin
                if (a[i] >= NUM_REGS) begin
                    rdy[i] = 1'b1; err = 1; last = i;
                end else if (used.size() < 2) begin
                    foreach (used[j]) if (used[j] == a[i]) clash = 1;
                    if (!clash) begin
                        rdy[i] = 1'b1; last = i;
                        if (ga < 0) ga = i; else gb = i;
                        used.push_back(a[i]);
                    end
                end
            end
        end
        nrr = (last < 0) ? rr : (last + 1) % 3;
    endfunction

    // Model: predicts Ready now and queues the port state expected next cycle.
    always @(negedge Clock) begin
        logic [2:0]        rdy;
        int                ga, gb, nrr;
        bit                err;
        int                a[3];
        logic [DATA_W-1:0] d[3];
        exp_t              e;
        started = 1;
        for (int i = 0; i < 3; i++) begin
            a[i] = int'(Req_Addr[i*ADDR_W +: ADDR_W]);
            d[i] = Req_Data[i*DATA_W +: DATA_W];
        end
        if (Reset || Hold) begin
            rdy = '0; ga = -1; gb = -1; err = 0; nrr = Reset ? 0 : m_rr;
        end else begin
            arbitrate(Req_Valid, a, m_rr, rdy, ga, gb, err, nrr);
        end
        checks++;
        if (Req_Ready !== rdy) begin
            errors++;
            $display("FAIL ready t=%0t got %b want %b", $time, Req_Ready, rdy);
        end
        if (Reset) begin
            m_aa = '0; m_da = '0; m_ab = '0; m_db = '0;
        end else begin
            if (ga >= 0) begin m_aa = ADDR_W'(a[ga]); m_da = d[ga]; end
            if (gb >= 0) begin m_ab = ADDR_W'(a[gb]); m_db = d[gb]; end
        end
        m_rr  = nrr;
        e.wa  = (ga >= 0);
        e.aa  = m_aa;
        e.da  = m_da;
        e.wb  = (gb >= 0);
        e.ab  = m_ab;
        e.db  = m_db;
        e.err = err;
        exp_q.push_back(e);
    end

    // Monitor: compares the registered outputs against the queued expectation.
    always @(posedge Clock) begin
        exp_t e, act;
        #2;
        act = '{Rd_Wen, Rd_WAddr, Rd_WData, Rs_Wen, Rs_WAddr, Rs_WData, Err_Addr};
        if (exp_q.size() == 0) begin
            if (started) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ports t=%0t got A(%b,%0d,%h) B(%b,%0d,%h) err %b want A(%b,%0d,%h) B(%b,%0d,%h) err %b",
                         $time, act.wa, act.aa, act.da, act.wb, act.ab, act.db, act.err,
                         e.wa, e.aa, e.da, e.wb, e.ab, e.db, e.err);
            end
            if (Rd_Wen === 1'b1 && Rs_Wen === 1'b1) begin
                checks++;
                if (Rd_WAddr === Rs_WAddr) begin
                    errors++;
                    $display("FAIL same_addr t=%0t got A=%0d B=%0d want distinct", $time, Rd_WAddr, Rs_WAddr);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic hld, input logic [2:0] v,
                       input int a0, input int a1, input int a2,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        Reset     = rst;
        Hold      = hld;
        Req_Valid = v;
        Req_Addr  = {ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
        Req_Data  = {d2, d1, d0};
        @(posedge Clock);
        #1;
    endtask

    function automatic int rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return int'($urandom_range(NUM_REGS, 127));
        if (r < 6)  return int'($urandom_range(0, 3));
        return int'($urandom_range(0, NUM_REGS - 1));
    endfunction

    initial begin
        logic [2:0]        xfer;
        logic [2:0]        pv;
        int                pa[3];
        logic [DATA_W-1:0] pd[3];

        // Reset with all requesters valid
        cyc(1, 0, 3'b111, 1, 2, 3, 16'h0001, 16'h0002, 16'h0003);
        cyc(1, 0, 3'b111, 1, 2, 3, 16'h0001, 16'h0002, 16'h0003);
        // Two grants, distinct addresses
        cyc(0, 0, 3'b011, 3, 5, 0, 16'h1111, 16'h2222, 16'h0000);
        // Out-of-range from req2 at RR=2
        cyc(0, 0, 3'b100, 0, 0, 20, 16'h0, 16'h0, 16'h3333);
        cyc(0, 0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        // Three valid: req2 waits one cycle
        cyc(0, 0, 3'b111, 1, 2, 3, 16'hA001, 16'hA002, 16'hA003);
        cyc(0, 0, 3'b100, 1, 2, 3, 16'hA001, 16'hA002, 16'hA003);
        // Same-address collision
        cyc(0, 0, 3'b011, 7, 7, 0, 16'hAAAA, 16'hBBBB, 16'h0);
        cyc(0, 0, 3'b010, 7, 7, 0, 16'hAAAA, 16'hBBBB, 16'h0);
        // Hold, then a grant, then reset right after it
        cyc(0, 1, 3'b010, 0, 9, 0, 16'h0, 16'h5555, 16'h0);
        cyc(0, 1, 3'b010, 0, 9, 0, 16'h0, 16'h5555, 16'h0);
        cyc(0, 1, 3'b010, 0, 9, 0, 16'h0, 16'h5555, 16'h0);
        cyc(0, 0, 3'b010, 0, 9, 0, 16'h0, 16'h5555, 16'h0);
        cyc(1, 0, 3'b010, 0, 9, 0, 16'h0, 16'h6666, 16'h0);
        cyc(0, 0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 16'h0);

        // Random traffic: requests stay stable until transferred
        pv = '0;
        for (int i = 0; i < 3; i++) begin pa[i] = 0; pd[i] = '0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] || xfer[i]) begin
                    pv[i] = ($urandom_range(0, 9) < 7);
                    pa[i] = rand_addr();
                    pd[i] = DATA_W'($urandom);
                end
            end
            Reset     = ($urandom_range(0, 99) == 0);
            Hold      = ($urandom_range(0, 9) == 0);
            Req_Valid = pv;
            Req_Addr  = {ADDR_W'(pa[2]), ADDR_W'(pa[1]), ADDR_W'(pa[0])};
            Req_Data  = {pd[2], pd[1], pd[0]};
            @(negedge Clock);
            xfer = Req_Valid & Req_Ready;
            @(posedge Clock);
            #1;
        end
        cyc(0, 0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        cyc(0, 0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
